// File: rtl/axis_pkg.sv
// Shared helpers and entry layout for the AXI-Stream output packer.
// Optional statistics counters are enabled with AXIS_PACK_STATS_EN.
package axis_pkg;

    function automatic int lanes(int tdata_w, int in_w);
        return tdata_w / in_w;
    endfunction

    function automatic int strb_w(int tdata_w);
        return tdata_w / 8;
    endfunction

    function automatic int lvl_w(int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEF_TDATA_W = 32;

    typedef struct packed {
        logic                     last;
        logic [DEF_TDATA_W/8-1:0] strb;
        logic [DEF_TDATA_W-1:0]   data;
    } axis_entry_t;

endpackage

// File: rtl/axis_out_packer_if.sv
// Result-element input and M_AXIS output bundle of the packer.
// master = packer side, slave = data path / downstream side.
interface axis_out_packer_if #(
    parameter int IN_WIDTH    = 8,
    parameter int TDATA_WIDTH = 32
);
    logic [IN_WIDTH-1:0]      in_data;
    logic                     in_valid;
    logic                     in_last;
    logic                     in_ready;
    logic                     M_AXIS_TREADY;
    logic [TDATA_WIDTH-1:0]   M_AXIS_TDATA;
    logic                     M_AXIS_TVALID;
    logic                     M_AXIS_TLAST;
    logic [TDATA_WIDTH/8-1:0] M_AXIS_TSTRB;

    modport master (
        input  in_data, in_valid, in_last, M_AXIS_TREADY,
        output in_ready, M_AXIS_TDATA, M_AXIS_TVALID,
        output M_AXIS_TLAST, M_AXIS_TSTRB
    );

    modport slave (
        output in_data, in_valid, in_last, M_AXIS_TREADY,
        input  in_ready, M_AXIS_TDATA, M_AXIS_TVALID,
        input  M_AXIS_TLAST, M_AXIS_TSTRB
    );
endinterface

// File: rtl/axis_out_packer_sync_fifo.sv
// Synchronous FIFO with level count; read data is zero while empty.
module sync_fifo
    import axis_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       valid,
    output logic [lvl_w(DEPTH)-1:0]    level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else if (clear) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign valid = (level != '0);
    assign rdata = valid ? mem[rp] : '0;

endmodule

// File: rtl/axis_out_packer.sv
// Packs result elements into M_AXIS words, TLAST from in_last or count.
// Define AXIS_PACK_STATS_EN to add stat_words / stat_packets outputs.
module axis_out_packer
    import axis_pkg::*;
#(
    parameter int IN_WIDTH             = 8,
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 4,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic [CNT_WIDTH-1:0]        beat_limit,
    output logic [lvl_w(FIFO_DEPTH)-1:0] fifo_level,
    axis_out_packer_if.master           bus
`ifdef AXIS_PACK_STATS_EN
    ,
    output logic [31:0]                 stat_words,
    output logic [31:0]                 stat_packets
`endif
);
    localparam int TW    = C_M_AXIS_TDATA_WIDTH;
    localparam int LANES = lanes(TW, IN_WIDTH);
    localparam int SW    = strb_w(TW);
    localparam int LW    = lvl_w(FIFO_DEPTH);
    localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1;

    typedef struct packed {
        logic          last;
        logic [SW-1:0] strb;
        logic [TW-1:0] data;
    } entry_t;

    logic [IW-1:0]        idx;
    logic [TW-1:0]        acc;
    logic [TW-1:0]        word;
    logic [SW-1:0]        strb;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] lim;
    logic [CNT_WIDTH-1:0] lim_eff;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 rdy_q;
    logic                 accept;
    logic                 hit;
    logic                 last;
    logic                 commit;
    logic                 push;
    logic                 pop;
    logic                 valid;
    logic [LW-1:0]        level;
    logic [LW-1:0]        lvl_nxt;
    entry_t               wr_e;
    entry_t               rd_e;

    assign bus.in_ready = rdy_q & ~clear;
    assign accept       = bus.in_valid & bus.in_ready;

    // The limit is taken live on a packet's first element, then held.
    assign lim_eff = (cnt == '0) ? beat_limit : lim;
    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
    assign hit     = (lim_eff != '0) && (cnt_inc == lim_eff);
    assign last    = bus.in_last | hit;
    assign commit  = (idx == IW'(LANES - 1)) | last;
    assign push    = accept & commit;
    assign pop     = valid & bus.M_AXIS_TREADY;

    always_comb begin
        word = acc;
        for (int l = 0; l < LANES; l++) begin
            if (idx == IW'(l)) word[l*IN_WIDTH +: IN_WIDTH] = bus.in_data;
        end
        strb = '0;
        for (int b = 0; b < SW; b++) begin
            strb[b] = (IW'((b * 8) / IN_WIDTH) <= idx);
        end
    end

    always_comb begin
        lvl_nxt = level;
        if (clear)             lvl_nxt = '0;
        else if (push && !pop) lvl_nxt = level + LW'(1);
        else if (!push && pop) lvl_nxt = level - LW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= (lvl_nxt != LW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            acc <= '0;
            cnt <= '0;
            lim <= '0;
        end else if (clear) begin
            idx <= '0;
            acc <= '0;
            cnt <= '0;
            lim <= '0;
        end else if (accept) begin
            if (cnt == '0) lim <= beat_limit;
            if (commit) begin
                idx <= '0;
                acc <= '0;
                cnt <= last ? '0 : cnt_inc;
            end else begin
                idx <= idx + IW'(1);
                acc <= word;
                cnt <= cnt_inc;
            end
        end
    end

    assign wr_e = '{last: last, strb: strb, data: word};

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push),
        .wdata (wr_e),
        .pop   (pop),
        .rdata (rd_e),
        .valid (valid),
        .level (level)
    );

    assign bus.M_AXIS_TVALID = valid;
    assign bus.M_AXIS_TDATA  = rd_e.data;
    assign bus.M_AXIS_TSTRB  = rd_e.strb;
    assign bus.M_AXIS_TLAST  = rd_e.last;
    assign fifo_level        = level;

`ifdef AXIS_PACK_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words   <= '0;
            stat_packets <= '0;
        end else if (clear) begin
            stat_words   <= '0;
            stat_packets <= '0;
        end else if (pop) begin
            stat_words <= stat_words + 32'd1;
            if (rd_e.last) stat_packets <= stat_packets + 32'd1;
        end
    end
`endif

endmodule
